// File: rtl/mux_scan_nxw.sv
// mux_scan_nxw: registered N-channel, W-bit selector with manual load and
// auto-scan rotation, output held behind a valid/ready register stage.
// Optional build macro MUX_SCAN_MASK_EN adds a per-channel enable mask
// (ch_mask) that auto-scan and manual loads respect.
module mux_scan_nxw #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      sel_load,
`ifdef MUX_SCAN_MASK_EN
  input  logic [CHANNELS-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      sel_switch
);

  localparam int                 CNT_W    = $clog2(DWELL + 1);
  localparam int                 NSEL     = 1 << SEL_W;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0]   SEL_LAST = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W:0]     CH_N     = (SEL_W + 1)'(CHANNELS);

  logic [WIDTH-1:0]    chan [CHANNELS];
  logic [CHANNELS-1:0] en;
  logic [NSEL-1:0]     en_x;
  logic                any_en;
  logic [CNT_W-1:0]    cnt, cnt_cur, cnt_nx;
  logic                mode_q;
  logic [SEL_W-1:0]    sel_nx, adv_sel, idx;
  logic                found, load_ok;

  // unpack the flat input bus into one word per channel
  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    assign chan[k] = data_in[k*WIDTH +: WIDTH];
  end

`ifdef MUX_SCAN_MASK_EN
  assign en = ch_mask;
`else
  assign en = '1;
`endif
  // zero-extended so an out-of-range select index reads as disabled
  assign en_x   = NSEL'(en);
  assign any_en = |en;

  // modulo-CHANNELS increment; works for non-power-of-2 channel counts
  function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] s);
    return (s == SEL_LAST) ? '0 : s + 1'b1;
  endfunction

  // next enabled channel above cur_sel with wrap; holds if none enabled
  always_comb begin
    adv_sel = cur_sel;
    idx     = cur_sel;
    found   = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = sel_inc(idx);
      if (!found && en_x[idx]) begin
        adv_sel = idx;
        found   = 1'b1;
      end
    end
  end

  // select/dwell next state; a valid manual load beats an auto advance
  always_comb begin
    cnt_cur = (mode && !mode_q) ? '0 : cnt;
    load_ok = sel_load && ({1'b0, sel_in} < CH_N) && en_x[sel_in];
    sel_nx  = cur_sel;
    cnt_nx  = cnt;
    if (!mode) begin
      cnt_nx = '0;
    end else if (cnt_cur == CNT_LAST) begin
      cnt_nx = '0;
      sel_nx = adv_sel;
    end else begin
      cnt_nx = cnt_cur + 1'b1;
    end
    if (load_ok) begin
      sel_nx = sel_in;
      cnt_nx = '0;
    end
  end

  // select state, dwell counter and change pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_sel    <= '0;
      cnt        <= '0;
      mode_q     <= 1'b0;
      sel_switch <= 1'b0;
    end else begin
      cur_sel    <= sel_nx;
      cnt        <= cnt_nx;
      mode_q     <= mode;
      sel_switch <= (sel_nx != cur_sel);
    end
  end

  // output register: refill when empty or being drained; hold on stall
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (any_en) begin
        out_data  <= chan[cur_sel];
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_nxw.sv
// tb_mux_scan_nxw: directed checks of mux_scan_nxw; a 4-channel DWELL=3
// instance plus a 3-channel DWELL=2 instance for non-power-of-2 wrap.
module tb_mux_scan_nxw;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode, sel_load, out_ready;
  logic [1:0]  sel_in;
  logic [31:0] data_in  = 32'h44_33_22_11;
  logic [23:0] data3    = 24'hCC_BB_AA;
  logic [7:0]  out_data, out_data3;
  logic        out_valid, out_valid3, sel_switch, sel_switch3;
  logic [1:0]  cur_sel, cur_sel3;
`ifdef MUX_SCAN_MASK_EN
  logic [3:0]  ch_mask  = 4'b1111;
  logic [2:0]  ch_mask3 = 3'b111;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mux_scan_nxw #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .DWELL(3)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .mode(mode), .sel_in(sel_in),
    .sel_load(sel_load),
`ifdef MUX_SCAN_MASK_EN
    .ch_mask(ch_mask),
`endif
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .cur_sel(cur_sel), .sel_switch(sel_switch));

  mux_scan_nxw #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .DWELL(2)) dut3 (
    .clk(clk), .rst(rst), .data_in(data3), .mode(mode), .sel_in(sel_in),
    .sel_load(sel_load),
`ifdef MUX_SCAN_MASK_EN
    .ch_mask(ch_mask3),
`endif
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready),
    .cur_sel(cur_sel3), .sel_switch(sel_switch3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dat(input int i);
    return 32'(8'h11 * (i + 1));
  endfunction

  initial begin
    rst = 1'b1; mode = 1'b0; sel_load = 1'b0; sel_in = 2'd0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sel", cur_sel, 0);
    chk("rst_sw", sel_switch, 0);

    rst = 1'b0;
    tick();
    chk("first_valid", out_valid, 1);
    chk("first_data", out_data, 32'h11);

    // manual load of channel 2
    sel_load = 1'b1; sel_in = 2'd2;
    tick();
    chk("ld2_sel", cur_sel, 2);
    chk("ld2_sw", sel_switch, 1);
    sel_load = 1'b0;
    tick();
    chk("ld2_sw_off", sel_switch, 0);
    chk("ld2_data", out_data, 32'h33);

    // reload of the same index: no pulse
    sel_load = 1'b1;
    tick();
    chk("re2_sel", cur_sel, 2);
    chk("re2_sw", sel_switch, 0);

    // index 3: valid for 4 channels, ignored by the 3-channel instance
    sel_in = 2'd3;
    tick();
    chk("ld3_sel", cur_sel, 3);
    chk("ld3_c3_sel", cur_sel3, 2);
    chk("ld3_c3_sw", sel_switch3, 0);

    sel_in = 2'd0;
    tick();
    chk("ld0_sel", cur_sel, 0);
    chk("ld0_c3_sel", cur_sel3, 0);
    sel_load = 1'b0;

    // auto scan
    mode = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("auto_sel", cur_sel, 32'((k / 3) % 4));
      chk("auto_sw", sel_switch, 32'(k % 3 == 0));
      chk("auto_data", out_data, dat(((k - 1) / 3) % 4));
      chk("c3_sel", cur_sel3, 32'((k / 2) % 3));
    end

    // stall: data frozen, selection keeps rotating
    out_ready = 1'b0;
    for (int k = 13; k <= 17; k++) begin
      tick();
      chk("stall_data", out_data, 32'h44);
      chk("stall_valid", out_valid, 1);
      chk("stall_sel", cur_sel, 32'((k / 3) % 4));
    end
    out_ready = 1'b1;
    tick();
    chk("unstall_data", out_data, 32'h22);
    chk("unstall_sel", cur_sel, 2);

    // load collides with auto advance at edge 21
    tick(); tick();
    sel_load = 1'b1; sel_in = 2'd1;
    tick();
    chk("prio_sel", cur_sel, 1);
    chk("prio_sw", sel_switch, 1);
    sel_load = 1'b0;
    tick();
    chk("prio_hold1", cur_sel, 1);
    tick();
    chk("prio_hold2", cur_sel, 1);
    tick();
    chk("prio_adv", cur_sel, 2);
    chk("prio_adv_sw", sel_switch, 1);

    // back to manual: selection holds
    mode = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("man_hold", cur_sel, 2);
    end

    // reset with a pending word
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_valid", out_valid, 0);
    chk("mrst_data", out_data, 0);
    chk("mrst_sel", cur_sel, 0);
    rst = 1'b0;
    tick();
    chk("mrst_recap_v", out_valid, 1);
    chk("mrst_recap_d", out_data, 32'h11);
    out_ready = 1'b1;

`ifdef MUX_SCAN_MASK_EN
    ch_mask = 4'b1010;
    mode = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("mask_sel", cur_sel, (k < 3) ? 32'd0 : (((k / 3) % 2 == 1) ? 32'd1 : 32'd3));
    end
    sel_load = 1'b1; sel_in = 2'd0;
    tick();
    chk("mask_ld0", cur_sel, 3);
    chk("mask_ld0_sw", sel_switch, 0);
    sel_load = 1'b0;
    ch_mask = 4'b0000;
    tick();
    chk("mask_none_v", out_valid, 0);
    ch_mask = 4'b1111;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
